// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard logic.
//   hz_state_e : hazard FSM states (RUN, MEM_WAIT)
//   fwd_sel_e  : operand forwarding mux select
//   RES_LOAD   : ResultSrc encoding of a load
//   PCSRC_SEQ  : PCSrc encoding of sequential fetch (no redirect)
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RES_LOAD  = 2'b01;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Forwarding select for one E-stage source operand.
//   rs_i             : E-stage source register
//   rd_m_i, rd_w_i   : destination registers in M and W
//   wr_m_i, wr_w_i   : M / W stage will write its destination
//   fwd_o            : FWD_M beats FWD_W beats FWD_RF
// Purely combinational; x0 is never forwarded since it reads as zero.
module forward_sel
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      wr_m_i,
  input  logic                      wr_w_i,
  output fwd_sel_e                  fwd_o
);

  logic rs_nz;
  assign rs_nz = (rs_i != '0);

  always_comb begin
    fwd_o = FWD_RF;
    if (rs_nz && wr_m_i && (rd_m_i == rs_i))      fwd_o = FWD_M;
    else if (rs_nz && wr_w_i && (rd_w_i == rs_i)) fwd_o = FWD_W;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller.
//   Inputs : D/E/M/W register indices, load/store/writeback qualifiers,
//            PCSrcE redirect, dmem_ready_i handshake, clk / rst (sync, high).
//   Outputs: PC/F/D/M enables, F/D/W synchronous clears, E-stage forwarding
//            selects, saturating stall and flush counters.
// Forwarding resolves RAW hazards, a load-use hazard costs one stall plus a
// D->E bubble, a redirect flushes F and D, and an unfinished data memory
// access freezes the whole pipeline (RUN/MEM_WAIT FSM). Only the FSM state and
// the counters are registered; every control is combinational.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic [1:0]                ResultSrcE_i,
  input  logic [1:0]                ResultSrcM_i,
  input  logic [2:0]                RegWriteM_i,
  input  logic [2:0]                RegWriteW_i,
  input  logic [1:0]                MemWriteM_i,
  input  logic [1:0]                PCSrcE_i,
  input  logic                      dmem_ready_i,
  output logic                      Fen_o,
  output logic                      Den_o,
  output logic                      Men_o,
  output logic                      Frst_o,
  output logic                      Drst_o,
  output logic                      Wrst_o,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o,
  output logic                      PCen_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  hz_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // ---------------- forwarding ----------------
  fwd_sel_e fwd_a, fwd_b;
  logic     wr_m, wr_w;
  assign wr_m = (RegWriteM_i != '0);
  assign wr_w = (RegWriteW_i != '0);

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i(Rs1E_i), .rd_m_i(RdM_i), .rd_w_i(RdW_i),
    .wr_m_i(wr_m), .wr_w_i(wr_w), .fwd_o(fwd_a)
  );

  forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i(Rs2E_i), .rd_m_i(RdM_i), .rd_w_i(RdW_i),
    .wr_m_i(wr_m), .wr_w_i(wr_w), .fwd_o(fwd_b)
  );

  assign ForwardAE_o = rst ? FWD_RF : fwd_a;
  assign ForwardBE_o = rst ? FWD_RF : fwd_b;

  // ---------------- hazard detection ----------------
  logic mem_acc, lw_stall, redirect, freeze;
  assign mem_acc  = (MemWriteM_i != '0) || (ResultSrcM_i == RES_LOAD);
  assign lw_stall = (ResultSrcE_i == RES_LOAD) && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign redirect = (PCSrcE_i != PCSRC_SEQ);
  // Frozen whenever memory is not ready and an access is pending: either the
  // RUN cycle that launches it or any MEM_WAIT cycle. A ready-high MEM_WAIT
  // cycle falls through to normal RUN rules.
  assign freeze   = !dmem_ready_i && (mem_acc || (state_q == MEM_WAIT));

  // ---------------- FSM next state + controls ----------------
  always_comb begin
    state_d = freeze ? MEM_WAIT : RUN;
    PCen_o  = 1'b1;
    Fen_o   = 1'b1;
    Den_o   = 1'b1;
    Men_o   = 1'b1;
    Frst_o  = 1'b0;
    Drst_o  = 1'b0;
    Wrst_o  = 1'b0;
    if (rst) begin
      Frst_o = 1'b1;
      Drst_o = 1'b1;
      Wrst_o = 1'b1;
    end else if (freeze) begin
      // Hold everything; clear W so a writeback is not repeated and unready
      // load data never lands. The held redirect is applied on exit.
      PCen_o = 1'b0;
      Fen_o  = 1'b0;
      Den_o  = 1'b0;
      Men_o  = 1'b0;
      Wrst_o = 1'b1;
    end else begin
      // A redirect squashes the load-use victim anyway, so it wins the stall.
      PCen_o = redirect || !lw_stall;
      Fen_o  = redirect || !lw_stall;
      Den_o  = redirect || !lw_stall;
      Frst_o = redirect;
      Drst_o = redirect || lw_stall;
    end
  end

  // ---------------- counters ----------------
  logic stall_evt, flush_evt;
  assign stall_evt = !rst && (!Fen_o || !Den_o || !Men_o);
  assign flush_evt = !rst && (Frst_o || Drst_o);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_evt && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
